// File: rtl/decode_stage.sv
// decode_stage: RV32I decode, operand capture, RAW scoreboard and valid/ready ID/EX register.
// Optional feature: define DECODE_WB_BYPASS_EN to forward writeback data into captured operands.
module decode_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ifValid,
  output logic            ifReady,
  input  logic [XLEN-1:0] ifInstr,
  input  logic [XLEN-1:0] ifPc,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  input  logic [XLEN-1:0] rs1Data,
  input  logic [XLEN-1:0] rs2Data,
  input  logic            wbValid,
  input  logic [4:0]      wbRd,
  input  logic [XLEN-1:0] wbData,
  input  logic            flush,
  output logic            exValid,
  input  logic            exReady,
  output logic [XLEN-1:0] exPc,
  output logic [XLEN-1:0] exRs1Val,
  output logic [XLEN-1:0] exRs2Val,
  output logic [XLEN-1:0] exImm,
  output logic [4:0]      exRd,
  output logic [2:0]      exFunct3,
  output logic [3:0]      exAluOp,
  output logic            exRegWrite,
  output logic            exIsLoad,
  output logic            exIsStore,
  output logic            exIsBranch,
  output logic            exIsJal,
  output logic            exIsJalr,
  output logic            exIsLui,
  output logic            exIsAuipc,
  output logic            exIllegal
);

  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcOp     = 7'b0110011;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [3:0]      alu_op;
    logic            reg_write;
    logic            is_load;
    logic            is_store;
    logic            is_branch;
    logic            is_jal;
    logic            is_jalr;
    logic            is_lui;
    logic            is_auipc;
    logic            illegal;
  } id_ex_t;

  logic [6:0]      opcode;
  logic [4:0]      rd;
  logic [2:0]      funct3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [XLEN-1:0] op1, op2;
  logic            use_rs1, use_rs2, writes;
  id_ex_t          dec;

  logic [31:0] pending_q, pending_d;
  logic        ex_valid_q, ex_valid_d;
  id_ex_t      id_ex_q, id_ex_d;

  logic [31:0] wb_clr, ex_busy, pend_eff, busy;
  logic        haz1, haz2, stall, fire;

  assign opcode = ifInstr[6:0];
  assign rd     = ifInstr[11:7];
  assign funct3 = ifInstr[14:12];
  assign rs1    = ifInstr[19:15];
  assign rs2    = ifInstr[24:20];

  assign imm_i = {{20{ifInstr[31]}}, ifInstr[31:20]};
  assign imm_s = {{20{ifInstr[31]}}, ifInstr[31:25], ifInstr[11:7]};
  assign imm_b = {{19{ifInstr[31]}}, ifInstr[31], ifInstr[7], ifInstr[30:25], ifInstr[11:8], 1'b0};
  assign imm_u = {ifInstr[31:12], 12'b0};
  assign imm_j = {{11{ifInstr[31]}}, ifInstr[31], ifInstr[19:12], ifInstr[20], ifInstr[30:21],
                  1'b0};

`ifdef DECODE_WB_BYPASS_EN
  assign op1 = (wbValid && wbRd == rs1 && rs1 != 5'd0) ? wbData : rs1Data;
  assign op2 = (wbValid && wbRd == rs2 && rs2 != 5'd0) ? wbData : rs2Data;
`else
  assign op1 = rs1Data;
  assign op2 = rs2Data;
`endif

  always_comb begin
    dec         = '0;
    use_rs1     = 1'b0;
    use_rs2     = 1'b0;
    writes      = 1'b0;
    dec.pc      = ifPc;
    dec.rs1_val = op1;
    dec.rs2_val = op2;
    dec.rd      = rd;
    dec.funct3  = funct3;
    case (opcode)
      OpcLui: begin
        dec.is_lui = 1'b1;
        writes     = 1'b1;
        dec.imm    = imm_u;
      end
      OpcAuipc: begin
        dec.is_auipc = 1'b1;
        writes       = 1'b1;
        dec.imm      = imm_u;
      end
      OpcJal: begin
        dec.is_jal = 1'b1;
        writes     = 1'b1;
        dec.imm    = imm_j;
      end
      OpcJalr: begin
        dec.is_jalr = 1'b1;
        writes      = 1'b1;
        use_rs1     = 1'b1;
        dec.imm     = imm_i;
      end
      OpcBranch: begin
        dec.is_branch = 1'b1;
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
        dec.imm       = imm_b;
        dec.alu_op    = 4'b1000;
      end
      OpcLoad: begin
        dec.is_load = 1'b1;
        writes      = 1'b1;
        use_rs1     = 1'b1;
        dec.imm     = imm_i;
      end
      OpcStore: begin
        dec.is_store = 1'b1;
        use_rs1      = 1'b1;
        use_rs2      = 1'b1;
        dec.imm      = imm_s;
      end
      OpcOpImm: begin
        writes     = 1'b1;
        use_rs1    = 1'b1;
        dec.imm    = imm_i;
        // Only shifts (funct3 101) take bit 30 as an ALU modifier; elsewhere it is immediate data
        dec.alu_op = {(funct3 == 3'b101) & ifInstr[30], funct3};
      end
      OpcOp: begin
        writes     = 1'b1;
        use_rs1    = 1'b1;
        use_rs2    = 1'b1;
        dec.alu_op = {ifInstr[30], funct3};
      end
      default: dec.illegal = 1'b1;
    endcase
    dec.reg_write = writes & (rd != 5'd0);
  end

  always_comb begin
    wb_clr  = wbValid ? (32'd1 << wbRd) : 32'd0;
    ex_busy = (ex_valid_q && id_ex_q.reg_write) ? (32'd1 << id_ex_q.rd) : 32'd0;
`ifdef DECODE_WB_BYPASS_EN
    pend_eff = pending_q & ~wb_clr;
`else
    // Without forwarding, wait one cycle for the register file to commit the write
    pend_eff = pending_q | wb_clr;
`endif
    busy  = pend_eff | ex_busy;
    haz1  = use_rs1 & (rs1 != 5'd0) & busy[rs1];
    haz2  = use_rs2 & (rs2 != 5'd0) & busy[rs2];
    stall = haz1 | haz2;
  end

  assign ifReady = (~ex_valid_q | exReady) & ~stall;
  assign fire    = ifValid & ifReady;

  always_comb begin
    ex_valid_d = ex_valid_q;
    id_ex_d    = id_ex_q;
    if (flush) begin
      ex_valid_d = 1'b0;
    end else if (fire) begin
      ex_valid_d = 1'b1;
      id_ex_d    = dec;
    end else if (exReady) begin
      ex_valid_d = 1'b0;
    end
  end

  always_comb begin
    pending_d = pending_q;
    if (wbValid) pending_d[wbRd] = 1'b0;
    if (ex_valid_q && exReady && !flush && id_ex_q.reg_write) pending_d[id_ex_q.rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      id_ex_q    <= '0;
      pending_q  <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      id_ex_q    <= id_ex_d;
      pending_q  <= pending_d;
    end
  end

  assign exValid    = ex_valid_q;
  assign exPc       = id_ex_q.pc;
  assign exRs1Val   = id_ex_q.rs1_val;
  assign exRs2Val   = id_ex_q.rs2_val;
  assign exImm      = id_ex_q.imm;
  assign exRd       = id_ex_q.rd;
  assign exFunct3   = id_ex_q.funct3;
  assign exAluOp    = id_ex_q.alu_op;
  assign exRegWrite = id_ex_q.reg_write;
  assign exIsLoad   = id_ex_q.is_load;
  assign exIsStore  = id_ex_q.is_store;
  assign exIsBranch = id_ex_q.is_branch;
  assign exIsJal    = id_ex_q.is_jal;
  assign exIsJalr   = id_ex_q.is_jalr;
  assign exIsLui    = id_ex_q.is_lui;
  assign exIsAuipc  = id_ex_q.is_auipc;
  assign exIllegal  = id_ex_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: expected ID/EX contents are queued at issue and compared
// when the execute handshake completes.
module tb_decode_stage;

  localparam logic [8:0] FRw    = 9'h100;
  localparam logic [8:0] FStore = 9'h040;
  localparam logic [8:0] FBr    = 9'h020;
  localparam logic [8:0] FJal   = 9'h010;
  localparam logic [8:0] FLui   = 9'h004;
  localparam logic [8:0] FIll   = 9'h001;

  logic        clk = 1'b0;
  logic        rst_n, ifValid, ifReady, wbValid, flush, exValid, exReady;
  logic [31:0] ifInstr, ifPc, rs1Data, rs2Data, wbData;
  logic [4:0]  rs1, rs2, wbRd, exRd;
  logic [31:0] exPc, exRs1Val, exRs2Val, exImm;
  logic [2:0]  exFunct3;
  logic [3:0]  exAluOp;
  logic        exRegWrite, exIsLoad, exIsStore, exIsBranch, exIsJal, exIsJalr;
  logic        exIsLui, exIsAuipc, exIllegal;

  logic [31:0] regs [32];
  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [31:0] imm;
    logic [20:0] ctrl;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .ifValid(ifValid), .ifReady(ifReady), .ifInstr(ifInstr),
    .ifPc(ifPc), .rs1(rs1), .rs2(rs2), .rs1Data(rs1Data), .rs2Data(rs2Data),
    .wbValid(wbValid), .wbRd(wbRd), .wbData(wbData), .flush(flush), .exValid(exValid),
    .exReady(exReady), .exPc(exPc), .exRs1Val(exRs1Val), .exRs2Val(exRs2Val), .exImm(exImm),
    .exRd(exRd), .exFunct3(exFunct3), .exAluOp(exAluOp), .exRegWrite(exRegWrite),
    .exIsLoad(exIsLoad), .exIsStore(exIsStore), .exIsBranch(exIsBranch), .exIsJal(exIsJal),
    .exIsJalr(exIsJalr), .exIsLui(exIsLui), .exIsAuipc(exIsAuipc), .exIllegal(exIllegal)
  );

  // Register-file model: initialised while reset is held, written by writeback.
  assign rs1Data = regs[rs1];
  assign rs2Data = regs[rs2];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= (i == 0) ? 32'd0 : (32'hA000_0000 | 32'(i));
    end else if (wbValid && wbRd != 5'd0) begin
      regs[wbRd] <= wbData;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] instr, input logic [31:0] pc,
                          input logic [31:0] imm, input logic [3:0] alu,
                          input logic [8:0] flags, input logic [31:0] v1,
                          input logic [31:0] v2);
    exp_t e;
    e.pc   = pc;
    e.v1   = v1;
    e.v2   = v2;
    e.imm  = imm;
    e.ctrl = {instr[11:7], instr[14:12], alu, flags};
    sb.push_back(e);
  endtask

  task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
    ifValid = 1'b1;
    ifInstr = instr;
    ifPc    = pc;
  endtask

  // Retire/discard the ID/EX entry if it leaves this cycle, then advance one clock.
  task automatic tick();
    exp_t e;
    if (exValid && flush) begin
      if (sb.size() > 0) void'(sb.pop_front());
    end else if (exValid && exReady) begin
      chk("sb_has_entry", {31'd0, sb.size() > 0}, 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("ex_pc", exPc, e.pc);
        chk("ex_rs1val", exRs1Val, e.v1);
        chk("ex_rs2val", exRs2Val, e.v2);
        chk("ex_imm", exImm, e.imm);
        chk("ex_ctrl", {11'd0, exRd, exFunct3, exAluOp, exRegWrite, exIsLoad, exIsStore,
            exIsBranch, exIsJal, exIsJalr, exIsLui, exIsAuipc, exIllegal}, {11'd0, e.ctrl});
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ifValid = 1'b0; ifInstr = 32'd0; ifPc = 32'd0;
    wbValid = 1'b0; wbRd = 5'd0; wbData = 32'd0; flush = 1'b0; exReady = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_exvalid", {31'd0, exValid}, 32'd0);
    chk("rst_ifready", {31'd0, ifReady}, 32'd1);
    chk("rst_eximm", exImm, 32'd0);
    chk("rst_pending", dut.pending_q, 32'd0);
    rst_n = 1'b1;

    // Immediate formats, back to back
    issue(32'hFE20_AE23, 32'h200); #1;            // SW x2,-4(x1)
    chk("sw_ready", {31'd0, ifReady}, 32'd1);
    push_exp(ifInstr, ifPc, 32'hFFFF_FFFC, 4'd0, FStore, regs[1], regs[2]);
    tick();
    issue(32'hFE20_8CE3, 32'h204); #1;            // BEQ x1,x2,-8
    chk("beq_ready", {31'd0, ifReady}, 32'd1);
    push_exp(ifInstr, ifPc, 32'hFFFF_FFF8, 4'b1000, FBr, regs[1], regs[2]);
    tick();
    issue(32'h0010_006F, 32'h208); #1;            // JAL x0,0x800
    push_exp(ifInstr, ifPc, 32'h0000_0800, 4'd0, FJal, regs[0], regs[1]);
    tick();
    issue(32'h1234_52B7, 32'h20C); #1;            // LUI x5,0x12345
    push_exp(ifInstr, ifPc, 32'h1234_5000, 4'd0, FRw | FLui, regs[8], regs[3]);
    tick();

    // Backpressure with LUI held in ID/EX
    exReady = 1'b0;
    issue(32'h0070_0313, 32'h210);                // ADDI x6,x0,7
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ifready", {31'd0, ifReady}, 32'd0);
      chk("bp_exvalid", {31'd0, exValid}, 32'd1);
      chk("bp_eximm", exImm, 32'h1234_5000);
      chk("bp_expc", exPc, 32'h20C);
      chk("bp_pending", dut.pending_q, 32'd0);
      tick();
    end
    exReady = 1'b1; #1;
    chk("bp_release_ready", {31'd0, ifReady}, 32'd1);
    push_exp(ifInstr, ifPc, 32'd7, 4'd0, FRw, regs[0], regs[7]);
    tick();
    chk("bp_pending_set", dut.pending_q, 32'h0000_0020);

    // Reset mid-stream with ADDI x6 in ID/EX and x5 pending
    ifValid = 1'b0;
    rst_n = 1'b0; #1;
    chk("mrst_exvalid", {31'd0, exValid}, 32'd0);
    chk("mrst_pending", dut.pending_q, 32'd0);
    chk("mrst_ifready", {31'd0, ifReady}, 32'd1);
    sb.delete();
    tick();
    rst_n = 1'b1;

    issue(32'h0050_0093, 32'h300); #1;            // ADDI x1,x0,5
    chk("addi_ready", {31'd0, ifReady}, 32'd1);
    push_exp(ifInstr, ifPc, 32'd5, 4'd0, FRw, regs[0], regs[5]);
    tick();

    // RAW hazard on x3
    issue(32'h0010_0193, 32'h304); #1;            // ADDI x3,x0,1
    chk("raw_first_ready", {31'd0, ifReady}, 32'd1);
    push_exp(ifInstr, ifPc, 32'd1, 4'd0, FRw, regs[0], regs[1]);
    tick();
    issue(32'h0031_8233, 32'h308); #1;            // ADD x4,x3,x3
    chk("raw_stall_ex", {31'd0, ifReady}, 32'd0);
    tick();
    chk("raw_stall_pend", {31'd0, ifReady}, 32'd0);
    chk("raw_pending3", dut.pending_q, 32'h0000_000A);
    tick();
    wbValid = 1'b1; wbRd = 5'd3; wbData = 32'd1; #1;
`ifdef DECODE_WB_BYPASS_EN
    chk("raw_wb_fire", {31'd0, ifReady}, 32'd1);
    push_exp(ifInstr, ifPc, 32'd0, 4'd0, FRw, 32'd1, 32'd1);
    tick();
    wbValid = 1'b0;
`else
    chk("raw_wb_stall", {31'd0, ifReady}, 32'd0);
    tick();
    wbValid = 1'b0; #1;
    chk("raw_after_wb_ready", {31'd0, ifReady}, 32'd1);
    push_exp(ifInstr, ifPc, 32'd0, 4'd0, FRw, 32'd1, 32'd1);
    tick();
`endif
    ifValid = 1'b0; #1;
    tick();
    chk("raw_pending_after", dut.pending_q, 32'h0000_0012);

    // Flush coincident with fire: instruction dropped
    flush = 1'b1;
    issue(32'h0000_03B3, 32'h400); #1;            // ADD x7,x0,x0
    chk("flush_fire_ready", {31'd0, ifReady}, 32'd1);
    tick();
    flush = 1'b0; ifValid = 1'b0; #1;
    chk("flush_exvalid", {31'd0, exValid}, 32'd0);
    chk("flush_pending", dut.pending_q, 32'h0000_0012);

    // Flush of an occupied ID/EX: its rd must not become pending
    issue(32'h0000_0433, 32'h404); #1;            // ADD x8,x0,x0
    push_exp(ifInstr, ifPc, 32'd0, 4'd0, FRw, 32'd0, 32'd0);
    tick();
    ifValid = 1'b0; flush = 1'b1; #1;
    tick();
    flush = 1'b0; #1;
    chk("flush2_exvalid", {31'd0, exValid}, 32'd0);
    chk("flush2_pending", dut.pending_q, 32'h0000_0012);

    // Retire x1 and x4
    wbValid = 1'b1; wbRd = 5'd1; wbData = 32'd5; #1;
    tick();
    wbRd = 5'd4; wbData = 32'd9; #1;
    tick();
    wbValid = 1'b0; #1;
    chk("wb_pending_clear", dut.pending_q, 32'd0);

    // x0 destination, x0 sources and illegal opcode
    issue(32'h4020_8033, 32'h500); #1;            // SUB x0,x1,x2
    chk("sub_x0_ready", {31'd0, ifReady}, 32'd1);
    push_exp(ifInstr, ifPc, 32'd0, 4'b1000, 9'h000, 32'd5, regs[2]);
    tick();
    issue(32'h0000_04B3, 32'h504); #1;            // ADD x9,x0,x0
    chk("x0_nostall", {31'd0, ifReady}, 32'd1);
    push_exp(ifInstr, ifPc, 32'd0, 4'd0, FRw, 32'd0, 32'd0);
    tick();
    issue(32'h4030_5513, 32'h508); #1;            // SRAI x10,x0,3
    chk("srai_ready", {31'd0, ifReady}, 32'd1);
    push_exp(ifInstr, ifPc, 32'h0000_0403, 4'b1101, FRw, 32'd0, 32'd1);
    tick();
    issue(32'hFFFF_FFFF, 32'h50C); #1;            // opcode 1111111
    chk("illegal_ready", {31'd0, ifReady}, 32'd1);
    push_exp(ifInstr, ifPc, 32'd0, 4'd0, FIll, regs[31], regs[31]);
    tick();
    ifValid = 1'b0; #1;
    tick();
    tick();
    chk("end_exvalid", {31'd0, exValid}, 32'd0);
    chk("end_sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
